// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the default register word addresses, the bit positions of the status
// word and the transmit FSM state encoding.
package mmio_pkg;

   // Default dmem word addresses of the two registers
   localparam logic [11:0] TX_ADDR_DEFAULT   = 12'hFF0;
   localparam logic [11:0] STAT_ADDR_DEFAULT = 12'hFF1;

   // Status word bit positions
   localparam int unsigned STAT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT  = 1;
   localparam int unsigned STAT_BUSY_BIT  = 2;
   localparam int unsigned STAT_OVF_BIT   = 3;
   // Repeats FULL; reserved so software can later read a real level here
   localparam int unsigned STAT_LEVEL_BIT = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with show-ahead read data.
// A push while full is accepted only when a pop happens on the same edge, in
// which case the count is unchanged. A pop while empty is ignored.
//
// Ports:
//   clk_i    clock, all state changes on its rising edge
//   rst_i    synchronous active-high reset (empties the FIFO)
//   push_i   write request, wdata_i is stored when accepted
//   wdata_i  write data
//   pop_i    read request, rdata_o is the entry being removed
//   rdata_o  oldest entry (valid when not empty)
//   full_o   count == DEPTH
//   empty_o  count == 0
//   count_o  number of stored entries
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign pop_ok  = pop_i && !empty_o;
   // The slot freed by a same-edge pop makes room for the push
   assign push_ok = push_i && (!full_o || pop_ok);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter living beside dmem.
// Stores to TX_ADDR queue data[7:0]; a store to STAT_ADDR with data[0] set
// clears the sticky overflow flag. Reads of STAT_ADDR return the status word
// one cycle later, like dmem.
//
// Ports:
//   clock         master clock
//   reset         synchronous active-high reset, aborts any frame in flight
//   address_dmem  dmem word address
//   data          store data
//   wren          store enable
//   q_mmio        registered status word (0 unless last address was STAT_ADDR)
//   sel_mmio      registered: last address hit one of the two registers
//   tx            serial line, idle high
//   tx_busy       FIFO non-empty or frame in progress
//   overflow      sticky: a byte was dropped because the FIFO was full
module mmio_uart_tx
   import mmio_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [11:0] TX_ADDR      = TX_ADDR_DEFAULT,
   parameter logic [11:0] STAT_ADDR    = STAT_ADDR_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_mmio,
   output logic        sel_mmio,
   output logic        tx,
   output logic        tx_busy,
   output logic        overflow
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BaudW-1:0] BaudReload = BaudW'(CLKS_PER_BIT - 1);

   tx_state_e        state_q;
   logic [BaudW-1:0] baud_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             tx_q;
   logic             busy_q;
   logic             overflow_q;
   logic             sel_q;
   logic [31:0]      rdata_q;

   logic             push_req;
   logic             clr_req;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_rdata;
   logic [CntW-1:0]  fifo_count;
   logic             push_ok;
   logic             drop;
   logic             frame_edge;
   logic             idle_next;
   logic [CntW-1:0]  count_nxt;
   logic [31:0]      stat_word;
   logic             unused_data;

   assign unused_data = ^data[31:8];

   assign push_req = wren && (address_dmem == TX_ADDR);
   assign clr_req  = wren && (address_dmem == STAT_ADDR) && data[0];

   // A new frame may start from IDLE or straight out of the last stop-bit cycle
   assign frame_edge = (state_q == StIdle) || ((state_q == StStop) && (baud_q == '0));
   assign fifo_pop   = frame_edge && !fifo_empty;
   assign idle_next  = frame_edge && fifo_empty;

   assign push_ok   = push_req && (!fifo_full || fifo_pop);
   assign drop      = push_req && fifo_full && !fifo_pop;
   assign count_nxt = fifo_count + CntW'(push_ok) - CntW'(fifo_pop);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (push_req),
      .wdata_i (data[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Transmit FSM; tx and tx_busy are registered from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= !idle_next || (count_nxt != '0);
         unique case (state_q)
            StIdle: begin
               if (!fifo_empty) begin
                  shift_q <= fifo_rdata;
                  baud_q  <= BaudReload;
                  tx_q    <= 1'b0;
                  state_q <= StStart;
               end
            end
            StStart: begin
               if (baud_q == '0) begin
                  baud_q  <= BaudReload;
                  bit_q   <= '0;
                  tx_q    <= shift_q[0];
                  state_q <= StData;
               end else begin
                  baud_q <= baud_q - BaudW'(1);
               end
            end
            StData: begin
               if (baud_q == '0) begin
                  baud_q  <= BaudReload;
                  shift_q <= shift_q >> 1;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= StStop;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q - BaudW'(1);
               end
            end
            StStop: begin
               if (baud_q == '0) begin
                  baud_q <= BaudReload;
                  if (!fifo_empty) begin
                     shift_q <= fifo_rdata;
                     tx_q    <= 1'b0;
                     state_q <= StStart;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  baud_q <= baud_q - BaudW'(1);
               end
            end
         endcase
      end
   end

   always_comb begin
      stat_word                 = '0;
      stat_word[STAT_EMPTY_BIT] = fifo_empty;
      stat_word[STAT_FULL_BIT]  = fifo_full;
      stat_word[STAT_BUSY_BIT]  = busy_q;
      stat_word[STAT_OVF_BIT]   = overflow_q;
      stat_word[STAT_LEVEL_BIT] = (fifo_count == CntW'(FIFO_DEPTH));
   end

   // Overflow flag and read port; a same-edge drop beats a clear
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow_q <= 1'b0;
         sel_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clr_req) begin
            overflow_q <= 1'b0;
         end
         sel_q   <= (address_dmem == TX_ADDR) || (address_dmem == STAT_ADDR);
         rdata_q <= (address_dmem == STAT_ADDR) ? stat_word : 32'h0;
      end
   end

   assign tx       = tx_q;
   assign tx_busy  = busy_q;
   assign overflow = overflow_q;
   assign sel_mmio = sel_q;
   assign q_mmio   = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Bytes expected on the line are queued when pushed; a serial monitor decodes
// each frame and compares it with the head of the queue.
module tb_mmio_uart_tx;

   localparam logic [11:0] TxAddr   = 12'hFF0;
   localparam logic [11:0] StatAddr = 12'hFF1;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_mmio;
   logic        sel_mmio;
   logic        tx;
   logic        tx_busy;
   logic        overflow;

   int          tests_run = 0;
   int          fails     = 0;
   logic [7:0]  exp_q[$];
   int unsigned frames_seen = 0;
   int unsigned mon_idx     = 0;
   logic        mon_active  = 1'b0;
   logic [7:0]  mon_byte    = 8'h00;

   mmio_uart_tx #(
      .CLKS_PER_BIT (4),
      .FIFO_DEPTH   (8),
      .TX_ADDR      (TxAddr),
      .STAT_ADDR    (StatAddr)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_mmio       (q_mmio),
      .sel_mmio     (sel_mmio),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the store is sampled on the following posedge
   task automatic write_word(input logic [11:0] a, input logic [31:0] d);
      address_dmem = a;
      data         = d;
      wren         = 1'b1;
      @(negedge clock);
      wren         = 1'b0;
      address_dmem = 12'h000;
      data         = 32'h0;
   endtask

   task automatic read_word(input logic [11:0] a);
      address_dmem = a;
      wren         = 1'b0;
      @(negedge clock);
      address_dmem = 12'h000;
   endtask

   task automatic push_byte(input logic [7:0] b);
      exp_q.push_back(b);
      write_word(TxAddr, {24'h0, b});
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (tx_busy !== 1'b0 && n < bound) begin
         @(negedge clock);
         n++;
      end
      if (n >= bound) check_val("idle_timeout", {31'b0, tx_busy}, 32'h0);
   endtask

   // Serial monitor: index 0 is the first cycle of the start bit
   always @(negedge clock) begin
      if (reset === 1'b1) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (tx === 1'b0) begin
            mon_active = 1'b1;
            mon_idx    = 0;
         end
      end else begin
         mon_idx++;
         if (mon_idx == 2) begin
            check_val("start_bit", {31'b0, tx}, 32'h0);
         end else if (mon_idx >= 6 && mon_idx <= 34 && ((mon_idx - 2) % 4) == 0) begin
            int k;
            k = int'((mon_idx - 6) / 4);
            mon_byte[k] = tx;
         end else if (mon_idx == 38) begin
            check_val("stop_bit", {31'b0, tx}, 32'h1);
            frames_seen++;
            check_val("sb_has_entry", {31'b0, (exp_q.size() != 0)}, 32'h1);
            if (exp_q.size() != 0) begin
               logic [7:0] e;
               e = exp_q.pop_front();
               check_val("frame_byte", {24'h0, mon_byte}, {24'h0, e});
            end
         end else if (mon_idx == 39) begin
            mon_active = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lows;
      int n;
      reset        = 1'b1;
      wren         = 1'b0;
      address_dmem = 12'h000;
      data         = 32'h0;
      repeat (3) @(negedge clock);

      // Reset state
      check_val("rst_tx", {31'b0, tx}, 32'h1);
      check_val("rst_busy", {31'b0, tx_busy}, 32'h0);
      check_val("rst_ovf", {31'b0, overflow}, 32'h0);
      check_val("rst_q", q_mmio, 32'h0);
      check_val("rst_sel", {31'b0, sel_mmio}, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      // Single byte: upper data bits ignored, start low over N+1..N+4
      exp_q.push_back(8'h55);
      write_word(TxAddr, 32'h0000_0155);
      check_val("one_tx_pre", {31'b0, tx}, 32'h1);
      lows = 0;
      repeat (4) begin
         @(negedge clock);
         if (tx === 1'b0) lows++;
      end
      check_val("one_start_len", lows, 32'd4);
      @(negedge clock);
      check_val("one_bit0", {31'b0, tx}, 32'h1);
      repeat (35) @(negedge clock);
      check_val("one_busy_n40", {31'b0, tx_busy}, 32'h1);
      @(negedge clock);
      check_val("one_busy_n41", {31'b0, tx_busy}, 32'h0);
      check_val("one_frames", frames_seen, 32'd1);

      // Back-to-back frames with no idle gap
      push_byte(8'h01);
      push_byte(8'h80);
      check_val("b2b_start1", {31'b0, tx}, 32'h0);
      repeat (39) @(negedge clock);
      check_val("b2b_stop1", {31'b0, tx}, 32'h1);
      @(negedge clock);
      check_val("b2b_start2", {31'b0, tx}, 32'h0);
      n = 40;
      while (tx_busy === 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check_val("b2b_busy_cycles", n, 32'd80);
      check_val("b2b_frames", frames_seen, 32'd3);

      // Overflow: 10 pushes, first pops at once, 8 queue, 10th dropped
      for (int i = 0; i < 10; i++) begin
         if (i < 9) begin
            push_byte(8'(8'h10 + i));
         end else begin
            write_word(TxAddr, 32'h10 + i);
         end
      end
      check_val("ovf_set", {31'b0, overflow}, 32'h1);
      read_word(StatAddr);
      check_val("ovf_stat_sel", {31'b0, sel_mmio}, 32'h1);
      check_val("ovf_stat_full", q_mmio, 32'h0000_001E);
      wait_idle(1000);
      check_val("ovf_sticky", {31'b0, overflow}, 32'h1);
      read_word(StatAddr);
      check_val("ovf_stat_idle", q_mmio, 32'h0000_0009);
      write_word(StatAddr, 32'h1);
      check_val("ovf_clear", {31'b0, overflow}, 32'h0);
      check_val("ovf_frames", frames_seen, 32'd12);

      // Status read while in DATA with 3 bytes queued
      for (int i = 0; i < 4; i++) push_byte(8'(8'h21 + i));
      repeat (5) @(negedge clock);
      read_word(StatAddr);
      check_val("stat_sel", {31'b0, sel_mmio}, 32'h1);
      check_val("stat_q", q_mmio, 32'h0000_0004);
      read_word(12'h010);
      check_val("other_sel", {31'b0, sel_mmio}, 32'h0);
      check_val("other_q", q_mmio, 32'h0);
      wait_idle(1000);
      check_val("stat_frames", frames_seen, 32'd16);

      // Full FIFO, push on the edge the last stop cycle pops
      for (int i = 0; i < 9; i++) push_byte(8'(8'h30 + i));
      repeat (32) @(negedge clock);
      push_byte(8'h39);
      check_val("fullpop_ovf", {31'b0, overflow}, 32'h0);
      read_word(StatAddr);
      check_val("fullpop_stat", q_mmio, 32'h0000_0016);
      wait_idle(2000);
      check_val("fullpop_frames", frames_seen, 32'd26);

      // Reset mid-frame discards the frame and the queue
      write_word(TxAddr, 32'h0000_00A5);
      write_word(TxAddr, 32'h0000_003C);
      repeat (13) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_val("mid_rst_tx", {31'b0, tx}, 32'h1);
      check_val("mid_rst_busy", {31'b0, tx_busy}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      read_word(StatAddr);
      check_val("mid_rst_stat", q_mmio, 32'h0000_0001);
      lows = 0;
      repeat (100) begin
         @(negedge clock);
         if (tx !== 1'b1) lows++;
      end
      check_val("mid_rst_quiet", lows, 32'd0);
      check_val("mid_rst_frames", frames_seen, 32'd26);
      check_val("sb_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
